span_pair_emitter: RTL and testbench

//  Upstream feeder of the frame-buffer write FIFO. It accepts one horizontal span per handshake:
//  x0..x1 inclusive on row y, flat colour, linear Z.
//  It walks the span two pixels (one 64-bit word) per cycle and issues one FIFO enqueue per word.

---
 rtl/span_pair_emitter_pkg.sv | 19 +
 rtl/span_pair_emitter_walker.sv | 43 ++++
 rtl/span_pair_emitter.sv | 134 +++++++++++++
 tb/tb_span_pair_emitter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/span_pair_emitter_pkg.sv
// rtl/span_pair_emitter_pkg.sv - shared frame-buffer widths, pixel order and FSM states
package span_pair_emitter_pkg;
   localparam int ADDR_W = 29;
   localparam int PIX_W  = 32;
   localparam int WORD_W = 64;

   // pixel_active bit order: left (even x) pixel in bit 0
   localparam int PA_LEFT  = 0;
   localparam int PA_RIGHT = 1;

   // a Z address of 0 tells the writer to skip the Z write
   localparam logic [ADDR_W-1:0] NO_WRITE_ADDR = '0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_EMIT
   } state_t;
endpackage

// File: rtl/span_pair_emitter_walker.sv
// rtl/span_pair_emitter_walker.sv - word pointer, left-pixel Z and pixel mask for one span
module span_pair_emitter_walker
   import span_pair_emitter_pkg::*;
#(
   parameter int X_BITS = 10
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                load,
   input  logic                step,
   input  logic [X_BITS-1:0]   x0,
   input  logic [X_BITS-1:0]   x1,
   input  logic [PIX_W-1:0]    z0,
   input  logic [PIX_W-1:0]    dzdx,
   output logic [X_BITS-2:0]   p,
   output logic                last,
   output logic [WORD_W-1:0]   z_pair,
   output logic [1:0]          pixel_active
);
   logic [X_BITS-2:0] p_end;
   logic [PIX_W-1:0]  z_left;

   always_ff @(posedge clock) begin
      if (reset) begin
         p      <= '0;
         p_end  <= '0;
         z_left <= '0;
      end else if (load) begin
         p      <= x0[X_BITS-1:1];
         p_end  <= x1[X_BITS-1:1];
         // an odd x0 starts mid-word, so back off one step to the even pixel
         z_left <= x0[0] ? z0 - dzdx : z0;
      end else if (step) begin
         p      <= p + {{(X_BITS-2){1'b0}}, 1'b1};
         z_left <= z_left + {dzdx[PIX_W-2:0], 1'b0};
      end
   end

   assign last                   = (p == p_end);
   assign z_pair                 = {z_left + dzdx, z_left};
   assign pixel_active[PA_LEFT]  = ({p, 1'b0} >= x0);
   assign pixel_active[PA_RIGHT] = ({p, 1'b1} <= x1);
endmodule

// File: rtl/span_pair_emitter.sv
// rtl/span_pair_emitter.sv - walks a flat-colour linear-Z span two pixels per FIFO enqueue
module span_pair_emitter
   import span_pair_emitter_pkg::*;
#(
   parameter int FB_WIDTH        = 800,
   parameter int X_BITS          = 10,
   parameter int Y_BITS          = 10,
   parameter int FIFO_DEPTH_LOG2 = 5,
   parameter int HIGH_WATER      = 28
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       span_valid,
   output logic                       span_ready,
   input  logic [X_BITS-1:0]          span_x0,
   input  logic [X_BITS-1:0]          span_x1,
   input  logic [Y_BITS-1:0]          span_y,
   input  logic [PIX_W-1:0]           span_color,
   input  logic [PIX_W-1:0]           span_z0,
   input  logic [PIX_W-1:0]           span_dzdx,
   input  logic                       span_z_enable,
   input  logic [ADDR_W-1:0]          color_base,
   input  logic [ADDR_W-1:0]          z_base,
   input  logic [FIFO_DEPTH_LOG2-1:0] fifo_size,
   output logic                       enqueue,
   output logic [ADDR_W-1:0]          color_address,
   output logic [WORD_W-1:0]          color,
   output logic [ADDR_W-1:0]          z_address,
   output logic [WORD_W-1:0]          z,
   output logic [1:0]                 pixel_active
);
   localparam logic [FIFO_DEPTH_LOG2-1:0] HW        = FIFO_DEPTH_LOG2'(HIGH_WATER);
   localparam logic [31:0]                ROW_WORDS = 32'(FB_WIDTH / 2);

   state_t state, state_nxt;
   logic   take, load, issue;

   logic [X_BITS-1:0] x0_q, x1_q;
   logic [Y_BITS-1:0] y_q;
   logic [PIX_W-1:0]  color_q, z0_q, dzdx_q;
   logic              zen_q;
   logic [ADDR_W-1:0] cbase_q, zbase_q, row_off, p_ext;

   logic [X_BITS-2:0] p;
   logic              last;
   logic [WORD_W-1:0] z_pair;
   logic [1:0]        pa_w;

   always_ff @(posedge clock) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      span_ready = 1'b0;
      take       = 1'b0;
      load       = 1'b0;
      issue      = 1'b0;
      unique case (state)
         ST_IDLE: begin
            span_ready = !reset;
            // a reversed span is consumed here without ever leaving IDLE
            if (span_valid && !reset && (span_x1 >= span_x0)) begin
               take      = 1'b1;
               state_nxt = ST_SETUP;
            end
         end
         ST_SETUP: begin
            load      = 1'b1;
            state_nxt = ST_EMIT;
         end
         ST_EMIT: begin
            if (fifo_size < HW) begin
               issue = 1'b1;
               if (last) state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (take) begin
         x0_q    <= span_x0;
         x1_q    <= span_x1;
         y_q     <= span_y;
         color_q <= span_color;
         z0_q    <= span_z0;
         dzdx_q  <= span_dzdx;
         zen_q   <= span_z_enable;
         cbase_q <= color_base;
         zbase_q <= z_base;
      end
      if (load) row_off <= ADDR_W'({32'd0, y_q} * {{Y_BITS{1'b0}}, ROW_WORDS});
   end

   span_pair_emitter_walker #(.X_BITS(X_BITS)) u_walker (
      .clock        (clock),
      .reset        (reset),
      .load         (load),
      .step         (issue),
      .x0           (x0_q),
      .x1           (x1_q),
      .z0           (z0_q),
      .dzdx         (dzdx_q),
      .p            (p),
      .last         (last),
      .z_pair       (z_pair),
      .pixel_active (pa_w)
   );

   assign p_ext = {{(ADDR_W-X_BITS+1){1'b0}}, p};

   always_ff @(posedge clock) begin
      if (reset) begin
         enqueue       <= 1'b0;
         color_address <= '0;
         z_address     <= '0;
         color         <= '0;
         z             <= '0;
         pixel_active  <= '0;
      end else begin
         enqueue <= issue;
         if (issue) begin
            color_address <= cbase_q + row_off + p_ext;
            z_address     <= zen_q ? zbase_q + row_off + p_ext : NO_WRITE_ADDR;
            color         <= {2{color_q}};
            z             <= z_pair;
            pixel_active  <= pa_w;
         end
      end
   end
endmodule

// File: tb/tb_span_pair_emitter.sv
// tb/tb_span_pair_emitter.sv - self-checking bench for span_pair_emitter
module tb_span_pair_emitter;
   localparam int FB_WIDTH = 800;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        span_valid = 1'b0;
   logic        span_ready;
   logic [9:0]  span_x0 = '0, span_x1 = '0, span_y = '0;
   logic [31:0] span_color = '0, span_z0 = '0, span_dzdx = '0;
   logic        span_z_enable = 1'b0;
   logic [28:0] color_base = '0, z_base = '0;
   logic [4:0]  fifo_size = '0;
   logic        enqueue;
   logic [28:0] color_address, z_address;
   logic [63:0] color, z;
   logic [1:0]  pixel_active;

   span_pair_emitter dut (
      .clock(clock), .reset(reset), .span_valid(span_valid), .span_ready(span_ready),
      .span_x0(span_x0), .span_x1(span_x1), .span_y(span_y), .span_color(span_color),
      .span_z0(span_z0), .span_dzdx(span_dzdx), .span_z_enable(span_z_enable),
      .color_base(color_base), .z_base(z_base), .fifo_size(fifo_size),
      .enqueue(enqueue), .color_address(color_address), .color(color),
      .z_address(z_address), .z(z), .pixel_active(pixel_active)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [28:0] caddr;
      logic [28:0] zaddr;
      logic [63:0] wcolor;
      logic [63:0] wz;
      logic [1:0]  pa;
   } word_t;

   typedef struct {
      logic [9:0]  x0, x1, y;
      logic [31:0] color, z0, dzdx;
      logic        zen;
      logic [28:0] cb, zb;
   } span_t;

   int    n_checks = 0;
   int    n_fail = 0;
   int    cyc = 0;
   int    acc_cyc = 0;
   word_t obs_w[$];
   int    obs_c[$];
   word_t exp_q[$];

   always @(posedge clock) cyc++;

   always @(negedge clock) begin
      if (enqueue === 1'b1) begin
         obs_w.push_back('{color_address, z_address, color, z, pixel_active});
         obs_c.push_back(cyc);
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic clear_obs();
      obs_w.delete();
      obs_c.delete();
   endtask

   // Each pixel's Z is z0 + (x - x0) * dzdx; addresses are base + y*(FB_WIDTH/2) + word.
   task automatic build_expected(input span_t s);
      exp_q.delete();
      if (s.x1 >= s.x0) begin
         for (int w = int'(s.x0) / 2; w <= int'(s.x1) / 2; w++) begin
            word_t       e;
            logic [31:0] k;
            longint      a;
            k        = 32'(2 * w - int'(s.x0));
            a        = longint'(s.y) * (FB_WIDTH / 2) + w;
            e.caddr  = 29'(longint'(s.cb) + a);
            e.zaddr  = s.zen ? 29'(longint'(s.zb) + a) : 29'd0;
            e.wcolor = {s.color, s.color};
            e.wz     = {s.z0 + (k + 32'd1) * s.dzdx, s.z0 + k * s.dzdx};
            e.pa     = {(2 * w + 1 <= int'(s.x1)), (2 * w >= int'(s.x0))};
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic send_span(input span_t s, input string tag);
      int b = 0;
      span_x0 = s.x0; span_x1 = s.x1; span_y = s.y;
      span_color = s.color; span_z0 = s.z0; span_dzdx = s.dzdx;
      span_z_enable = s.zen; color_base = s.cb; z_base = s.zb;
      span_valid = 1'b1;
      while (span_ready !== 1'b1 && b < 50) begin
         tick();
         b++;
      end
      n_checks++;
      if (span_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_accept: span_ready=%b, required 1 within 50 cycles", tag, span_ready);
      end
      @(posedge clock);
      tick();
      acc_cyc    = cyc;
      span_valid = 1'b0;
      span_x0 = 10'($urandom); span_x1 = 10'($urandom); span_y = 10'($urandom);
      span_color = $urandom; span_z0 = $urandom; span_dzdx = $urandom;
      span_z_enable = 1'($urandom); color_base = 29'($urandom); z_base = 29'($urandom);
   endtask

   task automatic wait_words(input int n, input int bound, input bit rnd_fifo);
      int b = 0;
      while (obs_w.size() < n && b < bound) begin
         if (rnd_fifo) fifo_size = 5'($urandom_range(31, 24));
         tick();
         b++;
      end
      fifo_size = '0;
      repeat (4) tick();
   endtask

   function automatic span_t rand_span(input int maxlen);
      span_t s;
      s.x0    = 10'($urandom_range(799, 0));
      s.x1    = 10'((int'(s.x0) + int'($urandom_range(maxlen, 0)) > 799) ? 799
                    : int'(s.x0) + int'($urandom_range(maxlen, 0)));
      s.y     = 10'($urandom_range(1023, 0));
      s.color = $urandom; s.z0 = $urandom; s.dzdx = $urandom;
      s.zen   = 1'b1;
      s.cb    = 29'($urandom); s.zb = 29'($urandom);
      return s;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      n_checks++;
      if (span_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_ready: got %b required 0", span_ready);
      end
      n_checks++;
      if (enqueue !== 1'b0) begin
         n_fail++; $display("FAIL reset_enqueue: got %b required 0", enqueue);
      end
      n_checks++;
      if ({color_address, z_address, color, z, pixel_active} !== '0) begin
         n_fail++; $display("FAIL reset_data: got %h required 0",
                            {color_address, z_address, color, z, pixel_active});
      end
      reset = 1'b0;
      tick();
      n_checks++;
      if (span_ready !== 1'b1) begin
         n_fail++; $display("FAIL idle_ready: got %b required 1", span_ready);
      end
   endtask

   task automatic test_basic();
      span_t s;
      s.x0 = 10'd0; s.x1 = 10'd7; s.y = 10'd0; s.color = 32'hCAFE_0123;
      s.z0 = 32'd100; s.dzdx = 32'd1; s.zen = 1'b1; s.cb = 29'h1000; s.zb = 29'h2000;
      clear_obs(); build_expected(s); send_span(s, "basic"); wait_words(4, 30, 1'b0);
      n_checks++;
      if (obs_w.size() != exp_q.size()) begin
         n_fail++; $display("FAIL basic_count: got %0d required %0d", obs_w.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_w.size()) begin
         n_checks++;
         if (obs_w[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL basic_word%0d: got %h required %h", i, obs_w[i], exp_q[i]);
         end
         n_checks++;
         if (obs_c[i] != acc_cyc + 2 + i) begin
            n_fail++; $display("FAIL basic_timing%0d: got cycle %0d required %0d",
                               i, obs_c[i], acc_cyc + 2 + i);
         end
      end
      if (obs_w.size() == 4) begin
         n_checks++;
         if (obs_w[3].caddr !== 29'h1003 || obs_w[3].wz !== {32'd107, 32'd106}) begin
            n_fail++; $display("FAIL basic_last: got addr %h z %h required 1003 / 0000006b0000006a",
                               obs_w[3].caddr, obs_w[3].wz);
         end
      end
   endtask

   task automatic test_edges();
      span_t s;
      s = rand_span(0);
      s.x0 = 10'd3; s.x1 = 10'd4; s.y = 10'd2;
      clear_obs(); build_expected(s); send_span(s, "odd"); wait_words(2, 30, 1'b0);
      n_checks++;
      if (obs_w.size() != 2) begin
         n_fail++; $display("FAIL odd_count: got %0d required 2", obs_w.size());
      end else begin
         n_checks++;
         if (obs_w[0].caddr !== s.cb + 29'd801 || obs_w[0].pa !== 2'b10 || obs_w[0].wz[63:32] !== s.z0) begin
            n_fail++; $display("FAIL odd_word0: got addr %h pa %b zr %h required %h 10 %h",
                               obs_w[0].caddr, obs_w[0].pa, obs_w[0].wz[63:32], s.cb + 29'd801, s.z0);
         end
         n_checks++;
         if (obs_w[1] !== exp_q[1] || obs_w[1].pa !== 2'b01 || obs_w[1].wz[31:0] !== s.z0 + s.dzdx) begin
            n_fail++; $display("FAIL odd_word1: got %h required %h", obs_w[1], exp_q[1]);
         end
      end
      s = rand_span(0);
      s.x0 = 10'd5; s.x1 = 10'd5;
      clear_obs(); build_expected(s); send_span(s, "single"); wait_words(1, 30, 1'b0);
      n_checks++;
      if (obs_w.size() != 1) begin
         n_fail++; $display("FAIL single_count: got %0d required 1", obs_w.size());
      end else begin
         n_checks++;
         if (obs_w[0] !== exp_q[0] || obs_w[0].pa !== 2'b10) begin
            n_fail++; $display("FAIL single_word: got %h required %h", obs_w[0], exp_q[0]);
         end
      end
      s = rand_span(0);
      s.x0 = 10'd5; s.x1 = 10'd4;
      clear_obs(); send_span(s, "empty"); repeat (10) tick();
      n_checks++;
      if (obs_w.size() != 0 || span_ready !== 1'b1) begin
         n_fail++; $display("FAIL empty_span: got %0d words ready %b required 0 words ready 1",
                            obs_w.size(), span_ready);
      end
   endtask

   task automatic test_stall();
      span_t s;
      int    b = 0;
      s = rand_span(0);
      s.x0 = 10'd0; s.x1 = 10'd11;
      clear_obs(); build_expected(s); send_span(s, "stall");
      while (obs_w.size() < 1 && b < 20) begin
         tick();
         b++;
      end
      fifo_size = 5'd28;
      repeat (5) tick();
      n_checks++;
      if (obs_w.size() != 1 || enqueue !== 1'b0) begin
         n_fail++; $display("FAIL stall_hold: got %0d words enqueue %b required 1 word enqueue 0",
                            obs_w.size(), enqueue);
      end
      fifo_size = 5'd27;
      wait_words(6, 40, 1'b0);
      n_checks++;
      if (obs_w.size() != exp_q.size()) begin
         n_fail++; $display("FAIL stall_count: got %0d required %0d", obs_w.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_w.size()) begin
         n_checks++;
         if (obs_w[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL stall_word%0d: got %h required %h", i, obs_w[i], exp_q[i]);
         end
      end
      if (obs_c.size() >= 2) begin
         n_checks++;
         if (obs_c[1] != obs_c[0] + 6) begin
            n_fail++; $display("FAIL stall_resume: got cycle %0d required %0d", obs_c[1], obs_c[0] + 6);
         end
      end
   endtask

   task automatic test_z_disable();
      span_t s;
      s = rand_span(12);
      s.zen = 1'b0;
      clear_obs(); build_expected(s); send_span(s, "zdis"); wait_words(exp_q.size(), 40, 1'b0);
      n_checks++;
      if (obs_w.size() != exp_q.size()) begin
         n_fail++; $display("FAIL zdis_count: got %0d required %0d", obs_w.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_w.size()) begin
         n_checks++;
         if (obs_w[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL zdis_word%0d: got %h required %h", i, obs_w[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      span_t s;
      int    b = 0;
      s = rand_span(0);
      s.x0 = 10'd0; s.x1 = 10'd7;
      clear_obs(); send_span(s, "rstmid");
      while (obs_w.size() < 2 && b < 20) begin
         tick();
         b++;
      end
      reset = 1'b1;
      tick();
      n_checks++;
      if (enqueue !== 1'b0 || span_ready !== 1'b0 || obs_w.size() != 2) begin
         n_fail++; $display("FAIL rstmid_stop: got enqueue %b ready %b words %0d required 0 0 2",
                            enqueue, span_ready, obs_w.size());
      end
      n_checks++;
      if ({color_address, z_address, color, z, pixel_active} !== '0) begin
         n_fail++; $display("FAIL rstmid_data: got %h required 0",
                            {color_address, z_address, color, z, pixel_active});
      end
      reset = 1'b0;
      repeat (5) tick();
      n_checks++;
      if (span_ready !== 1'b1 || obs_w.size() != 2) begin
         n_fail++; $display("FAIL rstmid_idle: got ready %b words %0d required 1 2",
                            span_ready, obs_w.size());
      end
      s = rand_span(0);
      s.x0 = 10'd0; s.x1 = 10'd1; s.z0 = 32'd0; s.dzdx = 32'hFFFF_FFFF;
      clear_obs(); build_expected(s); send_span(s, "wrap"); wait_words(1, 30, 1'b0);
      n_checks++;
      if (obs_w.size() != 1) begin
         n_fail++; $display("FAIL wrap_count: got %0d required 1", obs_w.size());
      end else begin
         n_checks++;
         if (obs_w[0] !== exp_q[0] || obs_w[0].wz !== {32'hFFFF_FFFF, 32'h0}) begin
            n_fail++; $display("FAIL wrap_word: got %h required %h", obs_w[0], exp_q[0]);
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 30; n++) begin
         span_t s;
         s = rand_span(40);
         s.zen = 1'($urandom);
         if ($urandom_range(7, 0) == 0) begin
            s.x1 = s.x0;
            s.x0 = (s.x0 == 10'd799) ? 10'd799 : s.x0 + 10'd1;
         end
         clear_obs(); build_expected(s); send_span(s, "rand");
         wait_words(exp_q.size(), 500, 1'b1);
         n_checks++;
         if (obs_w.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rand%0d_count: got %0d required %0d", n, obs_w.size(), exp_q.size());
         end
         foreach (exp_q[i]) if (i < obs_w.size()) begin
            n_checks++;
            if (obs_w[i] !== exp_q[i]) begin
               n_fail++; $display("FAIL rand%0d_word%0d: got %h required %h", n, i, obs_w[i], exp_q[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_edges();
      test_stall();
      test_z_disable();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
